// File: rtl/mc_phase_sequencer.sv
//------------------------------------------------------------------------------
// mc_phase_sequencer
//
// Multicycle phase sequencer for the CPU. It steps each instruction through
// IF / ID / EX / MEM / WB and drives one phase strobe at a time into the
// datapath: PC/NPC, RF, ALU, memory and IR_MDR. The instruction fields come
// from IR_MDR.
//
// Beyond the classic five-phase walk it provides three features:
//   * memory wait states: IF and MEM are each held for at least MEM_WAIT extra
//     cycles, and they complete only when mem_ready is high;
//   * a halt/park mode: the sequencer parks in IDLE at an instruction boundary;
//   * a retired-instruction counter that wraps modulo 2^CNT_W.
//
// Handshake (mem_ready): a memory phase (IF or MEM) completes on the first
// cycle in which the wait counter has reached MEM_WAIT and mem_ready is high.
// mem_ready is ignored in every other state.
//
// Parameters:
//   MEM_WAIT  minimum extra cycles that each memory phase is held
//   WAIT_W    width of the wait counter (must be able to hold MEM_WAIT)
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk          clock; all state changes happen on the rising edge
//   rst          synchronous reset, active-low
//   op, funct    opcode and funct field from the IR (stable after IF)
//   mem_ready    memory handshake for the IF and MEM phases
//   halt         park request, sampled at instruction end and in IDLE
//   IF_signal .. WB_signal   one-hot phase strobes (registered)
//   IorD_signal  memory address comes from the ALU (MEM phase)
//   IRWr         IR write pulse on the completing cycle of IF
//   mem_req      memory request (IF and MEM phases)
//   idle         sequencer is parked in IDLE
//   retired      count of completed instructions
//------------------------------------------------------------------------------
module mc_phase_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             IF_signal,
    output logic             ID_signal,
    output logic             EX_signal,
    output logic             MEM_signal,
    output logic             WB_signal,
    output logic             IorD_signal,
    output logic             IRWr,
    output logic             mem_req,
    output logic             idle,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;

    // ------------------------------------------------------------------
    // Instruction class decode. The IR is stable from the end of IF
    // onward, so decoding it in EX and again in MEM is safe.
    // ------------------------------------------------------------------
    logic is_load;
    logic is_store;
    logic is_short;   // finishes at the end of EX (jumps, jr, branches)

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_short = 1'b0;
        case (op)
            6'b100000, 6'b100001, 6'b100011,
            6'b100100, 6'b100101:             is_load  = 1'b1;
            6'b101000, 6'b101001, 6'b101011:  is_store = 1'b1;
            6'b000010,                                   // j
            6'b000100, 6'b000101, 6'b000001,
            6'b000110, 6'b000111:             is_short = 1'b1;
            6'b000000:                        is_short = (funct == 6'b001000); // jr
            default:                          ;          // ALU ops, jal, others -> WB
        endcase
    end

    // ------------------------------------------------------------------
    // Memory phase completion and instruction end.
    // ------------------------------------------------------------------
    logic mem_phase;
    logic mem_done;
    logic instr_end;

    always_comb begin
        mem_phase = (state == S_IF) || (state == S_MEM);
        mem_done  = mem_phase && (wait_cnt == WAIT_MAX) && mem_ready;
        instr_end = ((state == S_EX)  && is_short) ||
                    ((state == S_MEM) && mem_done && !is_load) ||
                    (state == S_WB);
    end

    // ------------------------------------------------------------------
    // Next-state logic. The park decision is taken only at an
    // instruction boundary, so halt never truncates an instruction.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = halt ? S_IDLE : S_IF;
            S_IF:    state_next = mem_done ? S_ID : S_IF;
            S_ID:    state_next = S_EX;
            S_EX: begin
                if (is_load || is_store) state_next = S_MEM;
                else if (!is_short)      state_next = S_WB;
                else                     state_next = halt ? S_IDLE : S_IF;
            end
            S_MEM: begin
                if (mem_done) begin
                    if (is_load) state_next = S_WB;
                    else         state_next = halt ? S_IDLE : S_IF;
                end
            end
            S_WB:    state_next = halt ? S_IDLE : S_IF;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, retired counter and registered Moore strobes.
    // The strobes are loaded from state_next so that they always match
    // the state register without an extra cycle of lag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            retired     <= '0;
            IF_signal   <= 1'b0;
            ID_signal   <= 1'b0;
            EX_signal   <= 1'b0;
            MEM_signal  <= 1'b0;
            WB_signal   <= 1'b0;
            IorD_signal <= 1'b0;
            mem_req     <= 1'b0;
            idle        <= 1'b1;
        end else begin
            state <= state_next;

            // The counter restarts on every state change. Within a memory
            // phase it counts up and saturates at MEM_WAIT.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (mem_phase && (wait_cnt < WAIT_MAX)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (instr_end) begin
                retired <= retired + CNT_W'(1);
            end

            IF_signal   <= (state_next == S_IF);
            ID_signal   <= (state_next == S_ID);
            EX_signal   <= (state_next == S_EX);
            MEM_signal  <= (state_next == S_MEM);
            WB_signal   <= (state_next == S_WB);
            IorD_signal <= (state_next == S_MEM);
            mem_req     <= (state_next == S_IF) || (state_next == S_MEM);
            idle        <= (state_next == S_IDLE);
        end
    end

    // The IR write must line up with the cycle in which the fetch
    // completes. It depends on mem_ready in that same cycle, so it
    // cannot be registered.
    assign IRWr = (state == S_IF) && mem_done;

endmodule
